onehot_timing_gen: RTL and testbench
====================================

# onehot_timing_gen

Parametrised one-hot timing-state generator for the RISC CPU control unit. It holds a registered state index and drives a registered one-hot decode of it (T0..Tn-1 strobes). The index can be advanced, loaded, or cleared, and wraps at a programmable terminal state. This lets short instructions end early without waiting for the full state ring. It replaces the fixed-width combinational decode formerly used to generate control strobes.

## Interface
Parameters:
- `IDX_W`, default 4: width of the state index.
- `NSTATE`, default `2**IDX_W`: number of timing states. Legal range is 2 ≤ NSTATE ≤ 2**IDX_W.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous return to state 0; also clears `err`.
- `load`  in  1  jump to `load_idx`.
- `load_idx`  in  IDX_W  target state for `load`.
- `en`  in  1  advance one state.
- `last_idx`  in  IDX_W  terminal state. Sampled every cycle.
- `onehot`  out  NSTATE  registered one-hot decode of the current state.
- `idx`  out  IDX_W  registered current state index.
- `wrap`  out  1  one-cycle pulse, high in the cycle `idx` returns to 0 via advance.
- `err`  out  1  sticky flag: an out-of-range load was attempted.

## Operation
- Reset values: `idx`=0, `onehot`=1 (bit 0 set), `wrap`=0, `err`=0.
- Per-cycle priority: `rst` > `clr` > `load` > `en` > hold.
- `clr`:
  - `idx` → 0, `onehot` → 1.
  - `wrap` → 0, `err` → 0.
- `load`:
  - If `load_idx` < NSTATE: `idx` → `load_idx`, `onehot` → 1<<`load_idx`, `wrap` → 0.
  - If `load_idx` ≥ NSTATE: state holds, `err` → 1 (sticky), `wrap` → 0.
- `en`: the effective terminal is `term` = min(`last_idx`, NSTATE-1).
  - If `idx` ≥ `term`: `idx` → 0, `wrap` → 1.
  - Otherwise: `idx` → `idx`+1, `wrap` → 0.
  - The ≥ comparison makes lowering `last_idx` below the current `idx` force a wrap on the next advance, never a runaway.
- Hold (no control input): state unchanged, `wrap` → 0.
- `load` and `en` asserted together: the load wins and no advance occurs.
- `err` is only cleared by `rst` or `clr`.

Invariants:
- `onehot` always has exactly one bit set.
- `onehot` == 1<<`idx` in every cycle.
- Bits above NSTATE do not exist.

## Timing
- All outputs are registered. A control input sampled at edge k is visible after edge k.
- Latency is 1 cycle. There is no combinational path from inputs to outputs.
- `wrap` coincides with the first cycle of `idx`=0 after a wrap. It never lasts more than one cycle, unless `en` stays high with `term`=0, in which case `wrap` asserts every cycle.
- Reset mid-sequence: the next cycle shows the reset values regardless of the other inputs.
- `last_idx` changes take effect on the same edge they are sampled.

## Structure
- Shared CPU package holds:
  - the `IDX_W`/NSTATE defaults for the control unit;
  - named constants for T-state indices (`T0`, `T1`, ...).
- One sub-module, `onehot_dec`: a parametrised combinational index → one-hot decoder (IDX_W in, NSTATE out).
  - Its output feeds the next-state `onehot` register.
  - The decode is computed from the next `idx` value, so `onehot` and `idx` update on the same edge.
- The top level contains only the next-index mux, the terminal compare, and the `err`/`wrap` flops.

## Test plan
- Reset and free run: `rst` for 2 cycles, then `en`=1, `last_idx`=15, for 18 cycles with NSTATE=16.
  - Expect `idx` 0,1,…,15,0,1; `onehot` 0x0001…0x8000,0x0001.
  - `wrap` high only at the first return to 0.
- Early terminal: `last_idx`=3, `en`=1.
  - Expect `idx` 0,1,2,3,0,1,2,3.
  - `wrap` high at each 0 after a 3.
  - Then set `last_idx`=1 while `idx`=3: next `idx`=0 with `wrap`=1.
- Load priority: with `idx`=5, assert `load`=1, `load_idx`=9, `en`=1 together.
  - Expect `idx`=9, `onehot`=0x0200, `wrap`=0.
  - Then `clr`=1 with `load`=1: expect `idx`=0.
- Out-of-range load, with NSTATE=12, IDX_W=4: assert `load_idx`=13.
  - Expect state unchanged and `err`=1.
  - `err` remains 1 through 5 `en` cycles, then returns to 0 one cycle after `clr`.
- Clamp: NSTATE=12, `last_idx`=15, `en`=1.
  - Expect the wrap after `idx`=11.
  - `onehot` never exceeds 0x800.
- Reset mid-run: assert `rst` at `idx`=7 together with `load`=1, `load_idx`=2.
  - Expect `idx`=0, `onehot`=1, `wrap`=0, `err`=0 the next cycle.

Source files
------------

// File: rtl/onehot_timing_gen_pkg.sv
// onehot_timing_gen_pkg: control-unit timing defaults and named T-state indices
package onehot_timing_gen_pkg;
    localparam int IDX_W_DEF  = 4;
    localparam int NSTATE_DEF = 1 << IDX_W_DEF;
    localparam logic [IDX_W_DEF-1:0] T0  = 4'd0;
    localparam logic [IDX_W_DEF-1:0] T1  = 4'd1;
    localparam logic [IDX_W_DEF-1:0] T2  = 4'd2;
    localparam logic [IDX_W_DEF-1:0] T3  = 4'd3;
    localparam logic [IDX_W_DEF-1:0] T4  = 4'd4;
    localparam logic [IDX_W_DEF-1:0] T5  = 4'd5;
    localparam logic [IDX_W_DEF-1:0] T6  = 4'd6;
    localparam logic [IDX_W_DEF-1:0] T7  = 4'd7;
    localparam logic [IDX_W_DEF-1:0] T8  = 4'd8;
    localparam logic [IDX_W_DEF-1:0] T9  = 4'd9;
    localparam logic [IDX_W_DEF-1:0] T10 = 4'd10;
    localparam logic [IDX_W_DEF-1:0] T11 = 4'd11;
    localparam logic [IDX_W_DEF-1:0] T12 = 4'd12;
    localparam logic [IDX_W_DEF-1:0] T13 = 4'd13;
    localparam logic [IDX_W_DEF-1:0] T14 = 4'd14;
    localparam logic [IDX_W_DEF-1:0] T15 = 4'd15;
endpackage

// File: rtl/onehot_timing_gen_dec.sv
// onehot_dec: combinational index to one-hot decoder
module onehot_dec
    import onehot_timing_gen_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int NSTATE = NSTATE_DEF
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [NSTATE-1:0] onehot
);
    // one bit per existing state; indices past NSTATE decode to nothing
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NSTATE; i++) onehot[i] = (idx == IDX_W'(i));
    end
endmodule

// File: rtl/onehot_timing_gen.sv
// onehot_timing_gen: registered timing-state index with one-hot strobes, load/clear and programmable wrap
module onehot_timing_gen
    import onehot_timing_gen_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int NSTATE = 1 << IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic              en,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [NSTATE-1:0] onehot,
    output logic [IDX_W-1:0]  idx,
    output logic              wrap,
    output logic              err
);
    localparam logic [IDX_W:0]   NS_X    = (IDX_W+1)'(NSTATE);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NSTATE - 1);

    logic [IDX_W-1:0]  term, idx_n;
    logic [NSTATE-1:0] onehot_n;
    logic              load_ok, at_term, wrap_n, err_n;

    // terminal clamp, legality check and priority mux clr > load > en > hold
    always_comb begin
        term    = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
        load_ok = {1'b0, load_idx} < NS_X;
        at_term = idx >= term;
        idx_n   = clr ? '0 :
                  load ? (load_ok ? load_idx : idx) :
                  en ? (at_term ? '0 : idx + 1'b1) : idx;
        wrap_n  = !clr && !load && en && at_term;
        err_n   = !clr && (err || (load && !load_ok));
    end

    onehot_dec #(.IDX_W(IDX_W), .NSTATE(NSTATE)) u_dec (
        .idx    (idx_n),
        .onehot (onehot_n)
    );

    // state, decoded strobes and flags all update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            onehot <= NSTATE'(1);
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            idx    <= idx_n;
            onehot <= onehot_n;
            wrap   <= wrap_n;
            err    <= err_n;
        end
    end
endmodule

// File: tb/tb_onehot_timing_gen.sv
// tb_onehot_timing_gen: directed table, corner sequences and random run against a reference model
module tb_onehot_timing_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1, clr = 1'b0, load = 1'b0, en = 1'b0;
    logic [3:0]  load_idx = '0, last_idx = '0;
    logic [15:0] oh16;
    logic [11:0] oh12;
    logic [3:0]  idx16, idx12;
    logic        wrap16, wrap12, err16, err12;

    int checks = 0, errors = 0;
    int m_idx[2]  = '{0, 0};
    int m_wrap[2] = '{0, 0};
    int m_err[2]  = '{0, 0};
    int ns[2]     = '{16, 12};

    typedef struct {
        bit       r, c, l, e;
        bit [3:0] li, last;
        int       x_idx, x_wrap, x_err;
    } vec_t;
    vec_t tbl[$];

    onehot_timing_gen #(.IDX_W(4), .NSTATE(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_idx(load_idx), .en(en),
        .last_idx(last_idx), .onehot(oh16), .idx(idx16), .wrap(wrap16), .err(err16)
    );
    onehot_timing_gen #(.IDX_W(4), .NSTATE(12)) dut12 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_idx(load_idx), .en(en),
        .last_idx(last_idx), .onehot(oh12), .idx(idx12), .wrap(wrap12), .err(err12)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(bit r, bit c, bit l, bit e, bit [3:0] li, bit [3:0] last,
                                int xi, int xw, int xe);
        vec_t v;
        v.r = r; v.c = c; v.l = l; v.e = e; v.li = li; v.last = last;
        v.x_idx = xi; v.x_wrap = xw; v.x_err = xe;
        tbl.push_back(v);
    endfunction

    // advance the model by one cycle from the current inputs, clock the DUTs, compare both
    task automatic step();
        int t;
        for (int d = 0; d < 2; d++) begin
            if (rst || clr) begin
                m_idx[d] = 0; m_wrap[d] = 0; m_err[d] = 0;
            end else if (load) begin
                m_wrap[d] = 0;
                if (int'(load_idx) < ns[d]) m_idx[d] = int'(load_idx);
                else m_err[d] = 1;
            end else if (en) begin
                t = (int'(last_idx) < ns[d] - 1) ? int'(last_idx) : ns[d] - 1;
                m_wrap[d] = (m_idx[d] >= t) ? 1 : 0;
                m_idx[d]  = (m_idx[d] >= t) ? 0 : m_idx[d] + 1;
            end else begin
                m_wrap[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("idx16", int'(idx16), m_idx[0]);
        chk("onehot16", int'(oh16), 1 << m_idx[0]);
        chk("wrap16", int'(wrap16), m_wrap[0]);
        chk("err16", int'(err16), m_err[0]);
        chk("idx12", int'(idx12), m_idx[1]);
        chk("onehot12", int'(oh12), 1 << m_idx[1]);
        chk("wrap12", int'(wrap12), m_wrap[1]);
        chk("err12", int'(err12), m_err[1]);
    endtask

    task automatic drive(bit r, bit c, bit l, bit e, bit [3:0] li, bit [3:0] last);
        rst = r; clr = c; load = l; en = e; load_idx = li; last_idx = last;
    endtask

    initial begin
        int es[9] = '{3, 0, 1, 2, 3, 0, 1, 2, 3};
        // reset, free run, early terminal, load priority, clear, reset mid-run
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 18; k++) add(0, 0, 0, 1, 0, 15, k % 16, (k == 16) ? 1 : 0, 0);
        for (int k = 0; k < 9; k++) add(0, 0, 0, 1, 0, 3, es[k], (es[k] == 0) ? 1 : 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 5, 15, 5, 0, 0);
        add(0, 0, 1, 1, 9, 15, 9, 0, 0);
        add(0, 1, 1, 0, 4, 15, 0, 0, 0);
        add(0, 0, 1, 0, 7, 15, 7, 0, 0);
        add(1, 0, 1, 1, 2, 15, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].li, tbl[i].last);
            step();
            chk($sformatf("tbl%0d_idx", i), int'(idx16), tbl[i].x_idx);
            chk($sformatf("tbl%0d_wrap", i), int'(wrap16), tbl[i].x_wrap);
            chk($sformatf("tbl%0d_err", i), int'(err16), tbl[i].x_err);
        end

        // clamp on NSTATE=12: last_idx=15 wraps after 11
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 1, 0, 15);
            step();
            chk("clamp_idx12", int'(idx12), k % 12);
            chk("clamp_wrap12", int'(wrap12), (k == 12) ? 1 : 0);
        end

        // out-of-range load on NSTATE=12, sticky err until clr
        drive(0, 0, 1, 0, 5, 15);
        step();
        chk("oor_pre_idx12", int'(idx12), 5);
        drive(0, 0, 1, 0, 13, 15);
        step();
        chk("oor_idx12", int'(idx12), 5);
        chk("oor_err12", int'(err12), 1);
        chk("oor_oh12", int'(oh12), 'h20);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0, 15);
            step();
            chk("oor_sticky12", int'(err12), 1);
        end
        drive(0, 1, 0, 0, 0, 15);
        step();
        chk("oor_clr_err12", int'(err12), 0);
        chk("oor_clr_idx12", int'(idx12), 0);

        // term=0 with en held: wrap every cycle
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            step();
            chk("term0_wrap16", int'(wrap16), 1);
        end

        // random mix against the model
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : last_idx);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
